boot_loader: RTL

Boot sequencer for the ROM/RAM pair. After reset and a `start` pulse, it holds the CPU in reset and asserts the ROM `boot` enable. It then walks a parameterised window of ROM word addresses and copies each word into RAM through a ready/valid write handshake. When the window is copied, it releases the ROM bus and the CPU reset. It sits between `rom`, `ram` and the CPU top level and is the only driver of the ROM `boot` line.

---
 rtl/boot_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Boot sequencer: holds the CPU in reset, copies a ROM word window into RAM over a
// ready/valid write port, then releases the CPU. Optional BOOT_CHECKSUM_EN adds a word-sum accumulator.
`timescale 1ns/1ps

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module boot_loader #(
  parameter int SRC_BASE  = 0,
  parameter int DEST_BASE = 0,
  parameter int LOAD_LEN  = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   rom_boot,
  output logic [`ADDR_SIZE-1:0]  rom_addr,
  input  logic [`WORD_SIZE-1:0]  rom_data,
  output logic                   ram_wr_en,
  input  logic                   ram_ready,
  output logic [`ADDR_SIZE-1:0]  ram_addr,
  output logic [`WORD_SIZE-1:0]  ram_wdata,
  output logic                   cpu_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic [`WORD_SIZE-1:0]  checksum
);

  localparam int AW    = `ADDR_SIZE;
  localparam int WW    = `WORD_SIZE;
  localparam int WORDS = LOAD_LEN / 2;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_load;
  logic            w_accept;
  logic            w_last;
  logic [CW-1:0]   r_word_cnt;
  logic [AW-1:0]   r_rom_addr;
  logic [AW-1:0]   r_ram_addr;
  logic [WW-1:0]   r_ram_wdata;
  logic            r_rom_boot;
  logic            r_cpu_rst_n;

  assign w_last = (r_word_cnt == CW'(WORDS - 1));

  // NOTE: every output of this block gets a default before the case so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = S_ADDR;
          w_load = 1'b1;
        end
      end
      S_ADDR:  w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        if (ram_ready) begin
          w_accept = 1'b1;
          w_next   = w_last ? S_DONE : S_ADDR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // rom_boot and cpu_rst_n are registered from the next state so they switch on the
  // same edge the state does.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rom_boot  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rom_boot  <= (w_next == S_ADDR) || (w_next == S_READ) || (w_next == S_WRITE);
      r_cpu_rst_n <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr  <= '0;
      r_ram_addr  <= '0;
      r_word_cnt  <= '0;
      r_ram_wdata <= '0;
    end else begin
      if (w_load) begin
        r_rom_addr <= AW'(SRC_BASE);
        r_ram_addr <= AW'(DEST_BASE);
        r_word_cnt <= '0;
      end else if (w_accept && !w_last) begin
        r_rom_addr <= r_rom_addr + AW'(2);
        r_ram_addr <= r_ram_addr + AW'(2);
        r_word_cnt <= r_word_cnt + CW'(1);
      end
      if (r_state == S_READ) begin
        r_ram_wdata <= rom_data;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [WW-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_load) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + r_ram_wdata;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign rom_boot  = r_rom_boot;
  assign rom_addr  = r_rom_addr;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign cpu_rst_n = r_cpu_rst_n;
  assign ram_wr_en = (r_state == S_WRITE);
  assign busy      = (r_state == S_ADDR) || (r_state == S_READ) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);

endmodule
